// File: rtl/synth_param_bank_pkg.sv
// Shared FSM encoding, parameter indices and default limit tables for synth_param_bank.
package synth_param_bank_pkg;

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

  localparam int unsigned PARAM_AMP = 0;
  localparam int unsigned PARAM_ATT = 1;
  localparam int unsigned PARAM_DEC = 2;
  localparam int unsigned PARAM_SUS = 3;
  localparam int unsigned PARAM_REL = 4;

  localparam int unsigned DEFAULT_NUM_PARAMS = PARAM_REL + 1;
  localparam int unsigned DEFAULT_WIDTH      = 31;

  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_TOP = DEFAULT_WIDTH'(1 << 30);
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_ZERO = '0;

  localparam logic [DEFAULT_NUM_PARAMS*DEFAULT_WIDTH-1:0] DEFAULT_MIN_FLAT = '0;
  localparam logic [DEFAULT_NUM_PARAMS*DEFAULT_WIDTH-1:0] DEFAULT_MAX_FLAT =
      {DEFAULT_NUM_PARAMS{DEFAULT_TOP}};
  // Param 0 sits in the LSBs.
  localparam logic [DEFAULT_NUM_PARAMS*DEFAULT_WIDTH-1:0] DEFAULT_DEF_FLAT =
      {DEFAULT_TOP, DEFAULT_ZERO, DEFAULT_TOP, DEFAULT_ZERO, DEFAULT_TOP};

endpackage

// File: rtl/param_sat_step.sv
// Saturating add/subtract of one value; the extra carry bit prevents wrap and underflow.
module param_sat_step
  import synth_param_bank_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] step,
  input  logic             dir,
  output logic [WIDTH-1:0] next
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  always_comb begin
    w_sum  = {1'b0, val} + {1'b0, step};
    w_diff = {1'b0, val} - {1'b0, step};
    if (dir) begin
      next = (w_sum > {1'b0, max}) ? max : w_sum[WIDTH-1:0];
    end else begin
      next = (w_diff[WIDTH] || (w_diff[WIDTH-1:0] < min)) ? min : w_diff[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/synth_param_bank.sv
// Bank of editable synth parameters with edge-triggered inc/dec, hold-to-repeat and restore.
module synth_param_bank
  import synth_param_bank_pkg::*;
#(
  parameter int unsigned NUM_PARAMS   = DEFAULT_NUM_PARAMS,
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned SEL_W        = 3,
  parameter int unsigned STEP         = 1 << 24,
  parameter int unsigned REPEAT_DELAY = 25_000_000,
  parameter int unsigned REPEAT_RATE  = 5_000_000,
  parameter logic [NUM_PARAMS*WIDTH-1:0] MIN_FLAT = DEFAULT_MIN_FLAT,
  parameter logic [NUM_PARAMS*WIDTH-1:0] MAX_FLAT = DEFAULT_MAX_FLAT,
  parameter logic [NUM_PARAMS*WIDTH-1:0] DEF_FLAT = DEFAULT_DEF_FLAT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        inc,
  input  logic                        dec,
  input  logic                        restore,
  output logic [NUM_PARAMS*WIDTH-1:0] params_flat,
  output logic [WIDTH-1:0]            sel_value,
  output logic                        changed,
  output logic                        at_limit
);

  localparam logic [WIDTH-1:0] StepW     = WIDTH'(STEP);
  localparam logic [31:0]      DelayLast = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0]      RateLast  = 32'(REPEAT_RATE - 1);

  state_e           r_state_q, w_state_d;
  logic [31:0]      r_cnt_q, w_cnt_d;
  logic             r_dir_q, w_dir_d;
  logic [WIDTH-1:0] r_params_q [NUM_PARAMS];
  logic [SEL_W-1:0] r_sel_q;
  logic             r_inc_q, r_dec_q, r_restore_q;
  logic             r_inc_arm_q, r_dec_arm_q, r_restore_arm_q;
  logic             r_changed_q;

  logic             w_sel_valid;
  logic [WIDTH-1:0] w_cur, w_min, w_max, w_def, w_step_next, w_new;
  logic             w_inc_rise, w_dec_rise, w_restore_rise, w_held;
  logic             w_step, w_step_dir, w_load, w_we;

  assign w_sel_valid = 32'(sel) < NUM_PARAMS;

  always_comb begin
    w_cur = '0;
    w_min = '0;
    w_max = '0;
    w_def = '0;
    for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
      if (32'(sel) == i) begin
        w_cur = r_params_q[i];
        w_min = MIN_FLAT[i*WIDTH +: WIDTH];
        w_max = MAX_FLAT[i*WIDTH +: WIDTH];
        w_def = DEF_FLAT[i*WIDTH +: WIDTH];
      end
    end
  end

  // An input held through reset must be seen low once before it can count as an edge.
  assign w_inc_rise     = inc & ~r_inc_q & r_inc_arm_q;
  assign w_dec_rise     = dec & ~r_dec_q & r_dec_arm_q;
  assign w_restore_rise = restore & ~r_restore_q & r_restore_arm_q;
  assign w_held         = r_dir_q ? inc : dec;

  always_comb begin
    w_state_d  = r_state_q;
    w_cnt_d    = r_cnt_q;
    w_dir_d    = r_dir_q;
    w_step     = 1'b0;
    w_step_dir = r_dir_q;
    w_load     = 1'b0;
    if (w_restore_rise && w_sel_valid) begin
      w_load    = 1'b1;
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else if (inc && dec) begin
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      case (r_state_q)
        StIdle: begin
          if (w_sel_valid && (w_inc_rise || w_dec_rise)) begin
            w_step     = 1'b1;
            w_step_dir = w_inc_rise;
            w_dir_d    = w_inc_rise;
            w_state_d  = StHold;
            w_cnt_d    = '0;
          end
        end
        StHold, StRepeat: begin
          if (!w_held || (sel != r_sel_q)) begin
            w_state_d = StIdle;
            w_cnt_d   = '0;
          end else if (r_cnt_q == ((r_state_q == StHold) ? DelayLast : RateLast)) begin
            w_step    = 1'b1;
            w_state_d = StRepeat;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt_q + 32'd1;
          end
        end
        default: begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  param_sat_step #(
    .WIDTH(WIDTH)
  ) u_sat_step (
    .val (w_cur),
    .min (w_min),
    .max (w_max),
    .step(StepW),
    .dir (w_step_dir),
    .next(w_step_next)
  );

  assign w_we  = w_load | w_step;
  assign w_new = w_load ? w_def : w_step_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state_q       <= StIdle;
      r_cnt_q         <= '0;
      r_dir_q         <= 1'b0;
      r_sel_q         <= '0;
      r_inc_q         <= 1'b0;
      r_dec_q         <= 1'b0;
      r_restore_q     <= 1'b0;
      r_inc_arm_q     <= 1'b0;
      r_dec_arm_q     <= 1'b0;
      r_restore_arm_q <= 1'b0;
      r_changed_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        r_params_q[i] <= DEF_FLAT[i*WIDTH +: WIDTH];
      end
    end else begin
      r_state_q       <= w_state_d;
      r_cnt_q         <= w_cnt_d;
      r_dir_q         <= w_dir_d;
      r_sel_q         <= sel;
      r_inc_q         <= inc;
      r_dec_q         <= dec;
      r_restore_q     <= restore;
      r_inc_arm_q     <= r_inc_arm_q | ~inc;
      r_dec_arm_q     <= r_dec_arm_q | ~dec;
      r_restore_arm_q <= r_restore_arm_q | ~restore;
      r_changed_q     <= w_we && (w_new != w_cur);
      for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
        if (w_we && (32'(sel) == i)) begin
          r_params_q[i] <= w_new;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PARAMS; g++) begin : gen_flat
    assign params_flat[g*WIDTH +: WIDTH] = r_params_q[g];
  end

  assign sel_value = w_sel_valid ? w_cur : '0;
  assign at_limit  = w_sel_valid && ((w_cur == w_min) || (w_cur == w_max));
  assign changed   = r_changed_q;

endmodule

// File: tb/tb_synth_param_bank.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_synth_param_bank;

  localparam int unsigned NP = 5;
  localparam int unsigned W  = 8;
  localparam logic [NP*W-1:0] MinF = '0;
  localparam logic [NP*W-1:0] MaxF = {5{8'd100}};
  localparam logic [NP*W-1:0] DefF = {5{8'd50}};

  logic            clk     = 1'b0;
  logic            reset   = 1'b0;
  logic [2:0]      sel     = 3'd0;
  logic            inc     = 1'b0;
  logic            dec     = 1'b0;
  logic            restore = 1'b0;
  logic [NP*W-1:0] params_flat;
  logic [W-1:0]    sel_value;
  logic            changed;
  logic            at_limit;

  synth_param_bank #(
    .NUM_PARAMS  (NP),
    .WIDTH       (W),
    .SEL_W       (3),
    .STEP        (10),
    .REPEAT_DELAY(8),
    .REPEAT_RATE (4),
    .MIN_FLAT    (MinF),
    .MAX_FLAT    (MaxF),
    .DEF_FLAT    (DefF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sel        (sel),
    .inc        (inc),
    .dec        (dec),
    .restore    (restore),
    .params_flat(params_flat),
    .sel_value  (sel_value),
    .changed    (changed),
    .at_limit   (at_limit)
  );

  typedef enum int {KParam, KChanged, KSelVal, KLimit} kind_e;
  typedef struct {
    int    cyc;
    string name;
    kind_e kind;
    int    idx;
    int    val;
  } exp_t;

  exp_t q[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue stays ordered by due cycle so the monitor only ever looks at the head.
  task automatic expect_at(input int dly, input string name, input kind_e kind, input int idx,
                           input int val);
    exp_t e;
    int   pos;
    e.cyc  = cyc + dly;
    e.name = name;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    pos    = q.size();
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc > e.cyc) pos = i;
    end
    q.insert(pos, e);
  endtask

  task automatic expect_all(input int dly, input string name, input int v0, input int v1,
                            input int v2, input int v3, input int v4);
    expect_at(dly, name, KParam, 0, v0);
    expect_at(dly, name, KParam, 1, v1);
    expect_at(dly, name, KParam, 2, v2);
    expect_at(dly, name, KParam, 3, v3);
    expect_at(dly, name, KParam, 4, v4);
  endtask

  task automatic press(input int p, input bit up, input int exp_v, input int exp_chg,
                       input string name);
    sel = 3'(p);
    if (up) inc = 1'b1;
    else dec = 1'b1;
    expect_at(1, {name, "_val"}, KParam, p, exp_v);
    expect_at(1, {name, "_chg"}, KChanged, 0, exp_chg);
    expect_at(1, {name, "_lim"}, KLimit, 0, int'(exp_v == 0 || exp_v == 100));
    tick(1);
    inc = 1'b0;
    dec = 1'b0;
    tick(1);
  endtask

  function automatic int actual(input kind_e k, input int idx);
    case (k)
      KParam:   return int'(params_flat[idx*W +: W]);
      KChanged: return int'(changed);
      KSelVal:  return int'(sel_value);
      default:  return int'(at_limit);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    int   act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = actual(e.kind, e.idx);
      vectors++;
      if (e.cyc != cyc || act != e.val) begin
        miscompares++;
        $display("FAIL %s idx=%0d cycle=%0d due=%0d: got %0d, expected %0d", e.name, e.idx,
                 cyc, e.cyc, act, e.val);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  int t3_up[6]  = '{60, 70, 80, 90, 100, 100};
  int t3_dn[6]  = '{40, 30, 20, 10, 0, 0};
  int t3_chg[6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    // Reset state.
    tick(3);
    expect_all(0, "rst_param", 50, 50, 50, 50, 50);
    expect_at(0, "rst_chg", KChanged, 0, 0);
    expect_at(0, "rst_selval", KSelVal, 0, 50);
    expect_at(0, "rst_lim", KLimit, 0, 0);
    reset = 1'b1;
    tick(2);

    // Single press held 3 cycles: one step only.
    sel = 3'd0;
    inc = 1'b1;
    expect_at(1, "t1_val", KParam, 0, 60);
    expect_at(1, "t1_chg", KChanged, 0, 1);
    expect_at(2, "t1_chg_low", KChanged, 0, 0);
    expect_at(3, "t1_hold", KParam, 0, 60);
    expect_at(3, "t1_selval", KSelVal, 0, 60);
    tick(3);
    inc = 1'b0;
    tick(2);

    // Hold 20 cycles: steps at 0, 8, 12, 16.
    sel = 3'd1;
    inc = 1'b1;
    expect_at(1, "t2_s0", KParam, 1, 60);
    expect_at(1, "t2_c0", KChanged, 0, 1);
    expect_at(8, "t2_pre8", KParam, 1, 60);
    expect_at(8, "t2_nochg8", KChanged, 0, 0);
    expect_at(9, "t2_s8", KParam, 1, 70);
    expect_at(9, "t2_c8", KChanged, 0, 1);
    expect_at(10, "t2_nochg10", KChanged, 0, 0);
    expect_at(12, "t2_pre12", KParam, 1, 70);
    expect_at(13, "t2_s12", KParam, 1, 80);
    expect_at(17, "t2_s16", KParam, 1, 90);
    expect_at(17, "t2_c16", KChanged, 0, 1);
    expect_at(20, "t2_hold", KParam, 1, 90);
    tick(20);
    inc = 1'b0;
    tick(2);
    expect_at(0, "t2_final", KParam, 1, 90);

    // Saturation at MAX (param2) and MIN (param4).
    for (int k = 0; k < 6; k++) press(2, 1'b1, t3_up[k], t3_chg[k], "t3_inc");
    for (int k = 0; k < 6; k++) press(4, 1'b0, t3_dn[k], t3_chg[k], "t3_dec");

    // inc and dec together, then an out-of-range selector.
    sel = 3'd0;
    inc = 1'b1;
    dec = 1'b1;
    expect_at(1, "t4_both_val", KParam, 0, 60);
    expect_at(1, "t4_both_chg", KChanged, 0, 0);
    tick(2);
    inc = 1'b0;
    dec = 1'b0;
    tick(1);
    sel = 3'd6;
    expect_at(0, "t4_sel6_val", KSelVal, 0, 0);
    expect_at(0, "t4_sel6_lim", KLimit, 0, 0);
    inc = 1'b1;
    expect_all(1, "t4_sel6_param", 60, 90, 100, 50, 0);
    expect_at(1, "t4_sel6_chg", KChanged, 0, 0);
    tick(1);
    inc = 1'b0;
    tick(1);

    // Sel change during REPEAT aborts without stepping; restore reloads the default.
    press(3, 1'b1, 60, 1, "t5_pre");
    press(3, 1'b1, 70, 1, "t5_pre");
    inc = 1'b1;
    expect_at(1, "t5_s0", KParam, 3, 80);
    expect_at(9, "t5_s8", KParam, 3, 90);
    tick(10);
    sel = 3'd0;
    expect_at(3, "t5_p3_kept", KParam, 3, 90);
    expect_at(3, "t5_p0_kept", KParam, 0, 60);
    expect_at(3, "t5_nochg", KChanged, 0, 0);
    expect_at(12, "t5_p0_late", KParam, 0, 60);
    expect_at(12, "t5_p3_late", KParam, 3, 90);
    tick(12);
    inc = 1'b0;
    tick(1);
    sel = 3'd3;
    restore = 1'b1;
    expect_at(1, "t5_rest_val", KParam, 3, 50);
    expect_at(1, "t5_rest_chg", KChanged, 0, 1);
    tick(1);
    restore = 1'b0;
    tick(1);
    restore = 1'b1;
    expect_at(1, "t5_rest2_val", KParam, 3, 50);
    expect_at(1, "t5_rest2_chg", KChanged, 0, 0);
    tick(1);
    restore = 1'b0;
    tick(1);

    // Reset in the middle of REPEAT; a held inc must not step after release.
    sel = 3'd4;
    inc = 1'b1;
    expect_at(1, "t6_s0", KParam, 4, 10);
    expect_at(9, "t6_s8", KParam, 4, 20);
    expect_at(13, "t6_s12", KParam, 4, 30);
    tick(14);
    reset = 1'b0;
    expect_all(0, "t6_rst", 50, 50, 50, 50, 50);
    expect_at(0, "t6_rst_chg", KChanged, 0, 0);
    tick(2);
    reset = 1'b1;
    expect_at(1, "t6_held1", KParam, 4, 50);
    expect_at(1, "t6_held1_chg", KChanged, 0, 0);
    expect_at(3, "t6_held3", KParam, 4, 50);
    tick(3);
    inc = 1'b0;
    tick(1);
    inc = 1'b1;
    expect_at(1, "t6_repress", KParam, 4, 60);
    expect_at(1, "t6_repress_chg", KChanged, 0, 1);
    tick(1);
    inc = 1'b0;
    tick(2);

    if (q.size() != 0) begin
      $display("FAIL leftover expectations: got %0d unchecked, expected 0", q.size());
      miscompares += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
